// File: rtl/ctrl_pkg.sv
// Shared control-bundle definitions for the ID-stage control unit and its pipeline consumer.
// Bundle widths, field bit positions, ALUOp encodings and unpack helpers.
package ctrl_pkg;

   localparam int WB_W  = 2;
   localparam int MEM_W = 3;
   localparam int EX_W  = 4;

   localparam int WB_REGWRITE  = 1;
   localparam int WB_MEMTOREG  = 0;

   localparam int MEM_MEMREAD  = 2;
   localparam int MEM_MEMWRITE = 1;
   localparam int MEM_BRANCH   = 0;

   localparam int EX_REGDST    = 3;
   localparam int EX_ALUOP_HI  = 2;
   localparam int EX_ALUOP_LO  = 1;
   localparam int EX_ALUSRC    = 0;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } alu_op_e;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } wb_ctrl_t;

   typedef struct packed {
      logic mem_read;
      logic mem_write;
      logic branch;
   } mem_ctrl_t;

   typedef struct packed {
      logic    reg_dst;
      alu_op_e alu_op;
      logic    alu_src;
   } ex_ctrl_t;

   function automatic wb_ctrl_t unpack_wb(input logic [WB_W-1:0] b);
      wb_ctrl_t c;
      c.reg_write  = b[WB_REGWRITE];
      c.mem_to_reg = b[WB_MEMTOREG];
      return c;
   endfunction

   function automatic mem_ctrl_t unpack_mem(input logic [MEM_W-1:0] b);
      mem_ctrl_t c;
      c.mem_read  = b[MEM_MEMREAD];
      c.mem_write = b[MEM_MEMWRITE];
      c.branch    = b[MEM_BRANCH];
      return c;
   endfunction

   // Reserved ALUOp code 11 is carried bit-for-bit; decode downstream decides its meaning.
   function automatic ex_ctrl_t unpack_ex(input logic [EX_W-1:0] b);
      ex_ctrl_t c;
      c.reg_dst = b[EX_REGDST];
      c.alu_op  = alu_op_e'(b[EX_ALUOP_HI:EX_ALUOP_LO]);
      c.alu_src = b[EX_ALUSRC];
      return c;
   endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline boundary: a payload register plus valid bit.
// Reset and bubble both load an all-zero, invalid entry.
module ctrl_stage_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         bubble,
   input  logic         valid_d,
   input  logic [W-1:0] d,
   output logic         valid,
   output logic [W-1:0] q
);

   // NOTE: payload is cleared along with valid so a bubble drives no stale fields downstream.
   always_ff @(posedge clk) begin
      if (rst || bubble) begin
         valid <= 1'b0;
         q     <= '0;
      end else begin
         valid <= valid_d;
         q     <= d;
      end
   end

endmodule

// File: rtl/ctrl_pipe_stager.sv
// Carries packed control bundles through ID/EX, EX/MEM and MEM/WB, unpacks them per stage,
// and produces the load-use stall and the MEM-stage branch resolution / flush.
module ctrl_pipe_stager
   import ctrl_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [WB_W-1:0]  id_wb,
   input  logic [MEM_W-1:0] id_mem,
   input  logic [EX_W-1:0]  id_ex,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic [REG_W-1:0] id_rd,
   input  logic             ex_zero,
   output logic             stall,
   output logic             flush,
   output logic             ex_reg_dst,
   output logic             ex_alu_src,
   output logic [1:0]       ex_alu_op,
   output logic             mem_read,
   output logic             mem_write,
   output logic             pc_src,
   output logic             wb_reg_write,
   output logic             wb_mem_to_reg,
   output logic [REG_W-1:0] wb_dest
);

   localparam int EX_PW  = WB_W + MEM_W + EX_W + 2 * REG_W;
   localparam int MEM_PW = WB_W + MEM_W + REG_W + 1;
   localparam int WB_PW  = WB_W + REG_W;

   logic              ex_valid;
   logic [EX_PW-1:0]  ex_q;
   logic [WB_W-1:0]   ex_wb_b;
   logic [MEM_W-1:0]  ex_mem_b;
   logic [EX_W-1:0]   ex_ex_b;
   logic [REG_W-1:0]  ex_rt;
   logic [REG_W-1:0]  ex_rd;
   logic [REG_W-1:0]  ex_dest;
   ex_ctrl_t          ex_c;

   logic              mem_valid;
   logic [MEM_PW-1:0] mem_q;
   logic [WB_W-1:0]   mem_wb_b;
   logic [MEM_W-1:0]  mem_mem_b;
   logic [REG_W-1:0]  mem_dest;
   logic              mem_zero;
   mem_ctrl_t         mem_c;

   logic              wb_valid;
   logic [WB_PW-1:0]  wb_q;
   logic [WB_W-1:0]   wb_wb_b;
   logic [REG_W-1:0]  wb_dest_q;
   wb_ctrl_t          wb_c;

   logic              hazard;
   logic              ex_bubble;
   logic              mem_bubble;
   logic              wb_bubble;

   assign {ex_wb_b, ex_mem_b, ex_ex_b, ex_rt, ex_rd} = ex_q;
   assign {mem_wb_b, mem_mem_b, mem_dest, mem_zero}  = mem_q;
   assign {wb_wb_b, wb_dest_q}                       = wb_q;

   assign ex_c  = unpack_ex(ex_ex_b);
   assign mem_c = unpack_mem(mem_mem_b);
   assign wb_c  = unpack_wb(wb_wb_b);

   assign ex_dest = ex_c.reg_dst ? ex_rd : ex_rt;

   // Branch resolves from MEM registers only, so flush never depends on ID-side inputs.
   assign pc_src = mem_valid & mem_c.branch & mem_zero;
   assign flush  = pc_src;

   assign hazard = ex_valid & ex_mem_b[MEM_MEMREAD] & id_valid & (ex_rt != '0) &
                   ((ex_rt == id_rs) | (ex_rt == id_rt));
   // A taken branch kills the load anyway, so the dependent needs no stall.
   assign stall  = hazard & ~pc_src;

   assign ex_bubble  = pc_src | stall | ~id_valid;
   assign mem_bubble = pc_src | ~ex_valid;
   assign wb_bubble  = ~mem_valid;

   ctrl_stage_reg #(.W(EX_PW)) u_ex_reg (
      .clk     (clk),
      .rst     (rst),
      .bubble  (ex_bubble),
      .valid_d (id_valid),
      .d       ({id_wb, id_mem, id_ex, id_rt, id_rd}),
      .valid   (ex_valid),
      .q       (ex_q)
   );

   ctrl_stage_reg #(.W(MEM_PW)) u_mem_reg (
      .clk     (clk),
      .rst     (rst),
      .bubble  (mem_bubble),
      .valid_d (ex_valid),
      .d       ({ex_wb_b, ex_mem_b, ex_dest, ex_zero}),
      .valid   (mem_valid),
      .q       (mem_q)
   );

   // On a flush WB still takes the branch itself; its RegWrite is 0 so it retires harmlessly.
   ctrl_stage_reg #(.W(WB_PW)) u_wb_reg (
      .clk     (clk),
      .rst     (rst),
      .bubble  (wb_bubble),
      .valid_d (mem_valid),
      .d       ({mem_wb_b, mem_dest}),
      .valid   (wb_valid),
      .q       (wb_q)
   );

   assign ex_reg_dst    = ex_valid & ex_c.reg_dst;
   assign ex_alu_src    = ex_valid & ex_c.alu_src;
   assign ex_alu_op     = {2{ex_valid}} & ex_c.alu_op;

   assign mem_read      = mem_valid & mem_c.mem_read;
   assign mem_write     = mem_valid & mem_c.mem_write;

   assign wb_reg_write  = wb_valid & wb_c.reg_write;
   assign wb_mem_to_reg = wb_valid & wb_c.mem_to_reg;
   assign wb_dest       = {REG_W{wb_valid}} & wb_dest_q;

   // Conflicting encodings are passed through; this only flags them in simulation.
   rw_conflict_a: assert property (@(posedge clk) disable iff (rst)
      ex_valid |-> !(ex_mem_b[MEM_MEMREAD] && ex_mem_b[MEM_MEMWRITE]))
      else $warning("ctrl_pipe_stager: MemRead and MemWrite both set in EX");

endmodule

// File: tb/tb_ctrl_pipe_stager.sv
// Directed scoreboard bench for ctrl_pipe_stager: stimulus queues per-cycle expected output
// vectors, a negedge monitor compares every entry due in the current cycle.
module tb_ctrl_pipe_stager;

   localparam int REG_W = 5;

   // Output vector: {stall, flush, ex_reg_dst, ex_alu_src, ex_alu_op[1:0], mem_read,
   //                 mem_write, pc_src, wb_reg_write, wb_mem_to_reg, wb_dest[4:0]}
   localparam logic [15:0] M_STALL = 16'h8000;
   localparam logic [15:0] M_FLUSH = 16'h4000;
   localparam logic [15:0] M_EX    = 16'h3C00;
   localparam logic [15:0] M_MEM   = 16'h0300;
   localparam logic [15:0] M_PC    = 16'h0080;
   localparam logic [15:0] M_WB    = 16'h007F;
   localparam logic [15:0] M_ALL   = 16'hFFFF;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             id_valid;
   logic [1:0]       id_wb;
   logic [2:0]       id_mem;
   logic [3:0]       id_ex;
   logic [REG_W-1:0] id_rs, id_rt, id_rd;
   logic             ex_zero;
   logic             stall, flush, ex_reg_dst, ex_alu_src;
   logic [1:0]       ex_alu_op;
   logic             mem_read, mem_write, pc_src;
   logic             wb_reg_write, wb_mem_to_reg;
   logic [REG_W-1:0] wb_dest;
   logic [15:0]      outv;

   int               cyc = 0;
   int               n_checks = 0;
   int               n_fail = 0;

   int               sb_key[$];
   logic [15:0]      sb_mask[$];
   logic [15:0]      sb_val[$];
   string            sb_name[$];
   int               kp_key[$];
   logic [15:0]      kp_mask[$];
   logic [15:0]      kp_val[$];
   string            kp_name[$];

   ctrl_pipe_stager #(.REG_W(REG_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .id_valid      (id_valid),
      .id_wb         (id_wb),
      .id_mem        (id_mem),
      .id_ex         (id_ex),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_rd         (id_rd),
      .ex_zero       (ex_zero),
      .stall         (stall),
      .flush         (flush),
      .ex_reg_dst    (ex_reg_dst),
      .ex_alu_src    (ex_alu_src),
      .ex_alu_op     (ex_alu_op),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .pc_src        (pc_src),
      .wb_reg_write  (wb_reg_write),
      .wb_mem_to_reg (wb_mem_to_reg),
      .wb_dest       (wb_dest)
   );

   assign outv = {stall, flush, ex_reg_dst, ex_alu_src, ex_alu_op, mem_read, mem_write,
                  pc_src, wb_reg_write, wb_mem_to_reg, wb_dest};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] want,
                        input logic [15:0] mask);
      n_checks++;
      if ((act & mask) !== (want & mask)) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %h, required %h (mask %h)",
                  name, cyc, act & mask, want & mask, mask);
      end
   endtask

   task automatic exp_at(input int key, input logic [15:0] mask, input logic [15:0] val,
                         input string name);
      sb_key.push_back(key);
      sb_mask.push_back(mask);
      sb_val.push_back(val);
      sb_name.push_back(name);
   endtask

   // Monitor: compare every scoreboard entry due this cycle, keep the rest.
   always @(negedge clk) begin
      kp_key.delete(); kp_mask.delete(); kp_val.delete(); kp_name.delete();
      foreach (sb_key[i]) begin
         if (sb_key[i] == cyc) begin
            check(sb_name[i], outv, sb_val[i], sb_mask[i]);
         end else begin
            kp_key.push_back(sb_key[i]);
            kp_mask.push_back(sb_mask[i]);
            kp_val.push_back(sb_val[i]);
            kp_name.push_back(sb_name[i]);
         end
      end
      sb_key = kp_key; sb_mask = kp_mask; sb_val = kp_val; sb_name = kp_name;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic id_set(input logic v, input logic [1:0] wb, input logic [2:0] mem,
                         input logic [3:0] ex, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd);
      id_valid = v; id_wb = wb; id_mem = mem; id_ex = ex;
      id_rs = rs; id_rt = rt; id_rd = rd;
   endtask

   task automatic id_nop();
      id_set(1'b0, 2'b00, 3'b000, 4'b0000, 5'd0, 5'd0, 5'd0);
   endtask

   task automatic id_rand();
      id_set(1'b1, 2'($urandom), 3'($urandom), 4'($urandom), 5'($urandom), 5'($urandom),
             5'($urandom));
   endtask

   task automatic drain(input int n);
      repeat (n) begin
         step();
         id_nop();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t;
      ex_zero = 1'b0;
      rst     = 1'b1;
      id_rand();

      // Reset held for two edges with random ID traffic
      exp_at(1, M_ALL, 16'h0000, "reset_hold");
      step();
      id_rand();
      exp_at(2, M_ALL, 16'h0000, "reset_release");
      step();
      rst = 1'b0;
      id_nop();

      // R-type: RegWrite, RegDst, ALUOp=FUNCT, rt=9, rd=8
      step();
      t = cyc;
      id_set(1'b1, 2'b10, 3'b000, 4'b1100, 5'd1, 5'd9, 5'd8);
      exp_at(t,     M_ALL,        16'h0000, "idle_after_reset");
      exp_at(t + 1, M_STALL|M_EX, 16'h2800, "rtype_ex");
      exp_at(t + 2, M_MEM,        16'h0000, "rtype_mem");
      exp_at(t + 3, M_WB,         16'h0048, "rtype_wb");
      drain(4);

      // Load-use: LW rt=5 then ADD rs=5; upstream holds ADD for the stall cycle
      step();
      t = cyc;
      id_set(1'b1, 2'b11, 3'b100, 4'b0001, 5'd2, 5'd5, 5'd0);
      exp_at(t + 1, M_STALL|M_EX,       16'h9000, "lu_stall");
      exp_at(t + 2, M_STALL|M_EX|M_MEM, 16'h0200, "lu_bubble");
      exp_at(t + 3, M_STALL|M_EX|M_WB,  16'h2865, "lu_add_ex_lw_wb");
      step();
      id_set(1'b1, 2'b10, 3'b000, 4'b1100, 5'd5, 5'd6, 5'd7);
      step();
      step();
      id_nop();
      drain(3);

      // Load into $0 never stalls its consumer
      step();
      t = cyc;
      id_set(1'b1, 2'b11, 3'b100, 4'b0001, 5'd3, 5'd0, 5'd0);
      exp_at(t + 1, M_STALL|M_EX,       16'h1000, "zero_reg_no_stall");
      exp_at(t + 2, M_STALL|M_EX|M_MEM, 16'h2A00, "zero_reg_consumer_ex");
      step();
      id_set(1'b1, 2'b10, 3'b000, 4'b1100, 5'd0, 5'd0, 5'd4);
      step();
      id_nop();
      drain(3);

      // Taken BEQ behind an R-type (rd=11), followed by R-type and store that get flushed
      step();
      t = cyc;
      id_set(1'b1, 2'b10, 3'b000, 4'b1100, 5'd1, 5'd2, 5'd11);
      exp_at(t + 2, M_PC|M_EX,                         16'h0400, "beq_ex");
      exp_at(t + 3, M_STALL|M_FLUSH|M_PC|M_MEM|M_WB,   16'h40CB, "beq_taken");
      exp_at(t + 4, M_ALL,                             16'h0002, "beq_flushed");
      exp_at(t + 5, M_ALL,                             16'h0000, "beq_drain");
      step();
      id_set(1'b1, 2'b00, 3'b001, 4'b0010, 5'd1, 5'd2, 5'd0);
      step();
      id_set(1'b1, 2'b10, 3'b000, 4'b1100, 5'd3, 5'd4, 5'd12);
      ex_zero = 1'b1;
      step();
      id_set(1'b1, 2'b00, 3'b010, 4'b0001, 5'd5, 5'd13, 5'd0);
      ex_zero = 1'b0;
      step();
      id_nop();
      drain(3);

      // Flush beats stall: BEQ in MEM, LW rt=7 in EX, dependent rs=7 in ID
      step();
      t = cyc;
      id_set(1'b1, 2'b00, 3'b001, 4'b0010, 5'd1, 5'd2, 5'd0);
      exp_at(t + 2, M_STALL|M_FLUSH|M_PC|M_EX, 16'h5080, "collision_flush_no_stall");
      exp_at(t + 3, M_ALL,                     16'h0002, "collision_bubbles");
      exp_at(t + 4, M_ALL,                     16'h0000, "collision_lw_no_wb");
      step();
      id_set(1'b1, 2'b11, 3'b100, 4'b0001, 5'd3, 5'd7, 5'd0);
      ex_zero = 1'b1;
      step();
      id_set(1'b1, 2'b10, 3'b000, 4'b1100, 5'd7, 5'd1, 5'd9);
      ex_zero = 1'b0;
      step();
      id_nop();
      drain(3);

      // Mid-run reset discards an in-flight R-type before it reaches WB
      step();
      t = cyc;
      id_set(1'b1, 2'b10, 3'b000, 4'b1100, 5'd1, 5'd2, 5'd14);
      exp_at(t + 2, M_ALL, 16'h0000, "reset_mid_clear");
      exp_at(t + 3, M_ALL, 16'h0000, "reset_mid_no_wb");
      step();
      rst = 1'b1;
      id_nop();
      step();
      rst = 1'b0;
      drain(4);

      foreach (sb_key[i]) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: expected at cycle %0d, never compared (now %0d)",
                  sb_name[i], sb_key[i], cyc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe_stager.md
# ctrl_pipe_stager

Consumer side of the ID-stage control bundles for the 5-stage MIPS pipeline. It latches the packed `wb`/`mem`/`ex` bundles from the control unit and carries them through the ID/EX, EX/MEM and MEM/WB boundaries. At each stage it unpacks the bundle into named control signals. It also generates the load-use stall, resolves BEQ in MEM, and inserts bubbles on stall and flush.

## Interface
Parameters:
- `REG_W`, default 5: register-specifier width.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `id_valid`  in  1  ID stage holds a real instruction
- `id_wb`  in  2  [1] RegWrite, [0] MemtoReg
- `id_mem`  in  3  [2] MemRead, [1] MemWrite, [0] Branch
- `id_ex`  in  4  [3] RegDst, [2:1] ALUOp, [0] ALUSrc
- `id_rs`, `id_rt`, `id_rd`  in  REG_W each  ID register specifiers
- `ex_zero`  in  1  ALU zero flag of the instruction currently in EX
- `stall`  out  1  load-use hazard; upstream holds PC and IF/ID
- `flush`  out  1  equals `pc_src`; upstream clears IF/ID
- `ex_reg_dst`, `ex_alu_src`  out  1 each; `ex_alu_op`  out  2
- `mem_read`, `mem_write`, `pc_src`  out  1 each
- `wb_reg_write`, `wb_mem_to_reg`  out  1 each; `wb_dest`  out  REG_W

## Operation
- There are three stage registers: EX, MEM and WB. Each holds a `valid` bit and the remaining bundle fields.
  - EX also holds `rt` and `rd`.
  - MEM holds `dest` and `zero`.
  - WB holds `dest`.
- `dest` is computed in EX as `RegDst ? rd : rt` and registered into MEM.
- The EX-to-MEM transfer carries `wb`, `mem`, `dest` and `ex_zero`. The MEM-to-WB transfer carries `wb` and `dest`.
- Every unpacked output is ANDed with its stage `valid`, so an invalid stage drives all zeros.
- `pc_src` = MEM.valid & MEM.Branch & MEM.zero. This signal is combinational from registers only.
- Hazard condition: EX.valid & EX.MemRead & id_valid & (EX.rt != 0) & (EX.rt == id_rs | EX.rt == id_rt).
- `stall` = hazard & ~pc_src. This is combinational from registers and ID inputs.
- Next-state priority, highest first:
  1. `rst`: all stage valids and fields go to 0.
  2. `pc_src`: EX and MEM load bubbles. WB loads the old MEM contents, which is the branch itself with RegWrite=0, so it is harmless.
  3. `stall`: EX loads a bubble. MEM and WB advance normally.
  4. Otherwise: EX loads ID if `id_valid`, else a bubble. MEM and WB advance.
- A bubble is valid=0 with all fields 0.
- Conflicting encodings, such as MemRead and MemWrite both set, are passed through unmodified. They are flagged by a simulation assertion only.

## Timing
- Reset value of every output is 0. Outputs become meaningful the cycle after `rst` deasserts.
- An ID bundle sampled at edge n drives the EX outputs in cycle n+1, the MEM outputs in n+2 and the WB outputs in n+3.
- `stall` and `pc_src` are visible in the same cycle as their cause. Their effect lands on the next edge.
- During a stall the upstream bundle is held, and it re-enters EX on the first non-stall edge. A stall lasts exactly one cycle per load-use pair.
- When a branch is taken, the two younger instructions (in EX and MEM after the flush edge) never assert `mem_write`, `mem_read` or `wb_reg_write`.
- If `rst` is asserted mid-operation, all in-flight instructions are discarded at that edge. No partial WB is produced.

## Structure
- Shared package `ctrl_pkg` holds:
  - bundle widths: WB_W=2, MEM_W=3, EX_W=4;
  - field bit indices, such as `WB_REGWRITE`=1 and `MEM_BRANCH`=0;
  - ALUOp encodings: ADD=00, SUB=01, FUNCT=10.
  
  The control unit imports the same package.
- One sub-module, `ctrl_stage_reg`: a parameterised-width register with a `valid` bit, synchronous `rst`, and a `bubble` input that loads zeros. It is instantiated three times.

## Test plan
- Reset: hold `rst` high for 2 cycles with random ID inputs. Every output must be 0 during reset and in the first cycle after release.
- R-type: ID presents id_wb=10, id_mem=000, id_ex=1100, rt=9, rd=8 at edge 0. Required response:
  - cycle 1: ex_reg_dst=1, ex_alu_op=10;
  - cycle 2: mem_read=0, mem_write=0;
  - cycle 3: wb_reg_write=1, wb_dest=8.
- Load-use: LW (id_ex=0001, rt=5) is followed by ADD with rs=5. Required response:
  - `stall`=1 for exactly one cycle;
  - the next cycle's EX outputs are all 0;
  - ADD reaches EX one cycle later;
  - LW reaches WB with wb_mem_to_reg=1, wb_dest=5.
- $0 load: LW with rt=0 followed by a consumer with rs=0 must produce `stall`=0.
- Branch taken: BEQ (id_mem=001, ex=0010) with ex_zero=1 in its EX cycle. Required response:
  - pc_src=flush=1 in its MEM cycle;
  - after the next edge, EX and MEM outputs are 0;
  - the instruction previously ahead in WB completes unchanged.
- Flush vs. stall collision: LW in EX with a dependent instruction in ID, while a taken BEQ is in MEM. Required response:
  - `stall`=0 and pc_src=1;
  - the next edge leaves EX and MEM as bubbles;
  - LW never produces wb_reg_write.
